mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Multicycle main control FSM with an integrated ALU-function decoder; sits directly upstream of the 32-bit ALU.
- Sequences each instruction through fetch/decode/execute/memory/writeback.
- Drives the ALU select line (AluCon) plus all datapath muxes and write enables.
- Consumes the ALU Zero flag to resolve branches.

Parameters:
- MEM_LAT, default 0: extra wait cycles spent in FETCH and MEMRD before the memory data is treated as valid; range 0..15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- Op  in  6  instruction opcode, taken from the instruction register
- Funct  in  6  R-type function field
- Zero  in  1  ALU zero flag
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register load
- RegDst  out  1  destination register select: 0=rt, 1=rd
- MemtoReg  out  1  writeback data select: 0=ALUOut, 1=MDR
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A select: 0=PC, 1=A register
- ALUSrcB  out  2  ALU B select: 00=B register, 01=constant 4, 10=sign-extended immediate, 11=sign-extended immediate shifted left 2
- PCSrc  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
- PCEn  out  1  PC load enable
- AluCon  out  3  ALU operation select
- State  out  4  current state, for debug

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low.
- State register: 4 bits. Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
- Output style: Moore outputs from State, except PCEn in BEQEX, which also depends on Zero.
- Reset:
  - State goes to FETCH and the wait counter to 0.
  - While rst_n=0, IRWrite, PCEn, MemWrite and RegWrite are forced to 0.
  - All other outputs show their FETCH values.
  - Reset mid-instruction abandons it and suppresses any pending write.
- Output defaults: every output not listed for a state is 0; AluCon defaults to 010 (add).
- AluCon encodings: and=000, or=001, add=010, sub=110, slt=111.
- Per-state outputs:
  - FETCH: ALUSrcA=0, ALUSrcB=01, AluCon=010, PCSrc=00. IRWrite=PCEn=1 only on the final FETCH cycle, i.e. when the wait counter equals MEM_LAT.
  - DECODE: ALUSrcA=0, ALUSrcB=11, add (computes the branch target).
  - MEMADR: ALUSrcA=1, ALUSrcB=10, add.
  - MEMRD: IorD=1, held for MEM_LAT+1 cycles.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
  - MEMWR: IorD=1, MemWrite=1, exactly 1 cycle.
  - RTEX: ALUSrcA=1, ALUSrcB=00, AluCon decoded from Funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - RTWB: RegDst=1, MemtoReg=0, RegWrite=1.
  - BEQEX: ALUSrcA=1, ALUSrcB=00, AluCon=110, PCSrc=01, PCEn=Zero.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, add.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
  - JEX: PCSrc=10, PCEn=1.
- Transitions:
  - FETCH→DECODE when the wait counter equals MEM_LAT; otherwise the counter increments and the FSM stays in FETCH.
  - DECODE dispatches on Op: 100011 (lw) and 101011 (sw)→MEMADR; 000000→RTEX; 000100→BEQEX; 001000→ADDIEX; 000010→JEX; any other opcode→FETCH, with no write of any kind.
  - DECODE with Op=000000 and an unsupported Funct→FETCH, with no writeback.
  - MEMADR→MEMRD for lw, →MEMWR for sw.
  - MEMRD→MEMWB after MEM_LAT+1 cycles, using the same counter.
  - MEMWB, MEMWR, RTWB, ADDIWB, BEQEX and JEX all return to FETCH.
  - RTEX→RTWB and ADDIEX→ADDIWB.
- Wait counter: cleared on every state change; never wraps past MEM_LAT.
- Op and Funct are sampled only in DECODE and RTEX; changes elsewhere have no effect.
- Cycle counts with MEM_LAT=0 (FETCH and DECODE included): lw=5, sw=4, R-type=4, addi=4, beq=3, j=3.

Optional Feature:
- Macro: MC_CTRL_BNE_EN.
- Defined: Op=000101 (bne) dispatches from DECODE to BEQEX. In BEQEX, PCEn=~Zero for bne and Zero for beq; a 1-bit branch-polarity register is latched in DECODE to select between them.
- Undefined: 000101 is an illegal opcode, DECODE→FETCH, and the polarity register is not present.

Test Plan:
- Reset: drive rst_n=0 mid-RTEX → State=0 immediately, RegWrite=PCEn=IRWrite=MemWrite=0; after release with MEM_LAT=0, the first cycle shows IRWrite=1 and PCEn=1.
- lw, Op=100011, MEM_LAT=0 → State sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in cycle 5.
- lw with MEM_LAT=2 → FETCH lasts 3 cycles with IRWrite only on the 3rd; MEMRD lasts 3 cycles; 9 cycles total.
- R-type, Funct=101010 → AluCon=111 in RTEX; RegDst=1 and RegWrite=1 in RTWB. Funct=000000 → returns to FETCH with no RegWrite.
- beq with Zero=1 → PCEn=1, PCSrc=01 in BEQEX. With Zero=0 → PCEn=0 and the next state is FETCH.
- Op=000101: with MC_CTRL_BNE_EN and Zero=0 → PCEn=1 in BEQEX; without the macro → DECODE→FETCH and no enable asserted.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multicycle main control FSM with built-in ALU-function decoder.
// Optional bne support is enabled by defining MC_CTRL_BNE_EN.
module mc_ctrl_fsm #(
  parameter int unsigned MEM_LAT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [2:0] AluCon,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StRtEx   = 4'd6,
    StRtWb   = 4'd7,
    StBeqEx  = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJEx    = 4'd11
  } state_e;

  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;
`ifdef MC_CTRL_BNE_EN
  localparam logic [5:0] OpBne   = 6'b000101;
`endif

  localparam logic [3:0] LatMax = 4'(MEM_LAT);

  // Returns {supported, alu_control}; unsupported codes fall back to add.
  function automatic logic [3:0] funct_dec(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b1010;
      6'b100010: return 4'b1110;
      6'b100100: return 4'b1000;
      6'b100101: return 4'b1001;
      6'b101010: return 4'b1111;
      default:   return 4'b0010;
    endcase
  endfunction

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       is_sw_q, is_sw_d;
  logic [3:0] fdec;
`ifdef MC_CTRL_BNE_EN
  logic       bne_q, bne_d;
`endif

  assign fdec  = funct_dec(Funct);
  assign State = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      cnt_q   <= '0;
      is_sw_q <= 1'b0;
`ifdef MC_CTRL_BNE_EN
      bne_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_sw_q <= is_sw_d;
`ifdef MC_CTRL_BNE_EN
      bne_q   <= bne_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_sw_d = is_sw_q;
`ifdef MC_CTRL_BNE_EN
    bne_d   = bne_q;
`endif
    case (state_q)
      StFetch, StMemRd: begin
        if (cnt_q == LatMax) begin
          state_d = (state_q == StFetch) ? StDecode : StMemWb;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDecode: begin
        is_sw_d = (Op == OpSw);
`ifdef MC_CTRL_BNE_EN
        bne_d   = (Op == OpBne);
`endif
        case (Op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = fdec[3] ? StRtEx : StFetch;
          OpBeq:      state_d = StBeqEx;
`ifdef MC_CTRL_BNE_EN
          OpBne:      state_d = StBeqEx;
`endif
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJEx;
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = is_sw_q ? StMemWr : StMemRd;
      StRtEx:   state_d = StRtWb;
      StAddiEx: state_d = StAddiWb;
      default:  state_d = StFetch;
    endcase
    // The wait counter only ever counts within a single state visit.
    if (state_d != state_q) cnt_d = '0;
  end

  always_comb begin
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSrc    = 2'b00;
    PCEn     = 1'b0;
    AluCon   = 3'b010;
    case (state_q)
      StFetch: begin
        ALUSrcB = 2'b01;
        IRWrite = (cnt_q == LatMax);
        PCEn    = (cnt_q == LatMax);
      end
      StDecode: ALUSrcB = 2'b11;
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StMemRd: IorD = 1'b1;
      StMemWb: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      StMemWr: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      StRtEx: begin
        ALUSrcA = 1'b1;
        AluCon  = fdec[2:0];
      end
      StRtWb: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      StBeqEx: begin
        ALUSrcA = 1'b1;
        AluCon  = 3'b110;
        PCSrc   = 2'b01;
`ifdef MC_CTRL_BNE_EN
        PCEn    = Zero ^ bne_q;
`else
        PCEn    = Zero;
`endif
      end
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StAddiWb: RegWrite = 1'b1;
      StJEx: begin
        PCSrc = 2'b10;
        PCEn  = 1'b1;
      end
      default: ;
    endcase
    // Reset holds off every write strobe regardless of state.
    if (!rst_n) begin
      IRWrite  = 1'b0;
      PCEn     = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: two instances (MEM_LAT=0 and MEM_LAT=2) driven by
// independent random instruction streams, checked cycle by cycle against a reference model.
module tb_mc_ctrl_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0_n, rst1_n;
  logic [5:0] op0, fn0, op1, fn1;
  logic       z0, z1;

  logic       iord0, memw0, irw0, regdst0, m2r0, regw0, srca0, pcen0;
  logic [1:0] srcb0, pcsrc0;
  logic [2:0] alu0;
  logic [3:0] st0;
  logic       iord1, memw1, irw1, regdst1, m2r1, regw1, srca1, pcen1;
  logic [1:0] srcb1, pcsrc1;
  logic [2:0] alu1;
  logic [3:0] st1;

  mc_ctrl_fsm #(.MEM_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .Op(op0), .Funct(fn0), .Zero(z0),
    .IorD(iord0), .MemWrite(memw0), .IRWrite(irw0), .RegDst(regdst0), .MemtoReg(m2r0),
    .RegWrite(regw0), .ALUSrcA(srca0), .ALUSrcB(srcb0), .PCSrc(pcsrc0), .PCEn(pcen0),
    .AluCon(alu0), .State(st0)
  );

  mc_ctrl_fsm #(.MEM_LAT(2)) dut1 (
    .clk(clk), .rst_n(rst1_n), .Op(op1), .Funct(fn1), .Zero(z1),
    .IorD(iord1), .MemWrite(memw1), .IRWrite(irw1), .RegDst(regdst1), .MemtoReg(m2r1),
    .RegWrite(regw1), .ALUSrcA(srca1), .ALUSrcB(srcb1), .PCSrc(pcsrc1), .PCEn(pcen1),
    .AluCon(alu1), .State(st1)
  );

  logic [18:0] v0, v1;
  assign v0 = {iord0, memw0, irw0, regdst0, m2r0, regw0, srca0, srcb0, pcsrc0, pcen0, alu0, st0};
  assign v1 = {iord1, memw1, irw1, regdst1, m2r1, regw1, srca1, srcb1, pcsrc1, pcen1, alu1, st1};

  int total = 0;
  int bad   = 0;
  logic [18:0] q0[$];
  logic [18:0] q1[$];
  bit mon_en0 = 1'b0;
  bit mon_en1 = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [18:0] act, input logic [18:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h (state %0d) expected %h (state %0d)",
               nm, $time, act, act[3:0], exp, exp[3:0]);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en0) begin
      if (q0.size() == 0) chk("inst0_underflow", 1, 0);
      else chk_vec("inst0_cycle", v0, q0.pop_front());
    end
    if (mon_en1) begin
      if (q1.size() == 0) chk("inst1_underflow", 1, 0);
      else chk_vec("inst1_cycle", v1, q1.pop_front());
    end
  end

  // Packed expected output vector, same field order as v0/v1.
  function automatic logic [18:0] pk(input int st, input bit iord, input bit memw,
                                     input bit irw, input bit regdst, input bit m2r,
                                     input bit regw, input bit srca, input int srcb,
                                     input int pcsrc, input bit pcen, input int alu);
    return {iord, memw, irw, regdst, m2r, regw, srca, 2'(srcb), 2'(pcsrc), pcen, 3'(alu),
            4'(st)};
  endfunction

  // Reference ALU-function table; -1 marks an unsupported R-type function.
  function automatic int funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 2;
      6'b100010: return 6;
      6'b100100: return 0;
      6'b100101: return 1;
      6'b101010: return 7;
      default:   return -1;
    endcase
  endfunction

  function automatic logic [5:0] rnd6();
    return 6'($urandom);
  endfunction

  function automatic bit rnd1();
    return 1'($urandom);
  endfunction

  task automatic cyc(input int inst, input logic [18:0] exp, input logic [5:0] op,
                     input logic [5:0] fn, input bit z);
    if (inst == 0) begin
      q0.push_back(exp);
      op0 = op; fn0 = fn; z0 = z;
    end else begin
      q1.push_back(exp);
      op1 = op; fn1 = fn; z1 = z;
    end
    @(posedge clk);
    #1;
  endtask

  // One instruction from its first FETCH cycle to its last cycle; unsampled inputs get junk.
  task automatic do_instr(input int inst, input int lat, input logic [5:0] op,
                          input logic [5:0] fn, input bit z);
    int a;
    bit bne_on;
`ifdef MC_CTRL_BNE_EN
    bne_on = 1'b1;
`else
    bne_on = 1'b0;
`endif
    for (int k = 0; k <= lat; k++)
      cyc(inst, pk(0, 0, 0, k == lat, 0, 0, 0, 0, 1, 0, k == lat, 2), rnd6(), rnd6(), rnd1());
    cyc(inst, pk(1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 2), op, fn, rnd1());
    if (op == 6'b100011 || op == 6'b101011) begin
      cyc(inst, pk(2, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 2), rnd6(), rnd6(), rnd1());
      if (op == 6'b100011) begin
        for (int k = 0; k <= lat; k++)
          cyc(inst, pk(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2), rnd6(), rnd6(), rnd1());
        cyc(inst, pk(4, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2), rnd6(), rnd6(), rnd1());
      end else begin
        cyc(inst, pk(5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2), rnd6(), rnd6(), rnd1());
      end
    end else if (op == 6'b000000) begin
      a = funct_alu(fn);
      if (a >= 0) begin
        cyc(inst, pk(6, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, a), rnd6(), fn, rnd1());
        cyc(inst, pk(7, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2), rnd6(), rnd6(), rnd1());
      end
    end else if (op == 6'b000100) begin
      cyc(inst, pk(8, 0, 0, 0, 0, 0, 0, 1, 0, 1, z, 6), rnd6(), rnd6(), z);
    end else if (op == 6'b000101 && bne_on) begin
      cyc(inst, pk(8, 0, 0, 0, 0, 0, 0, 1, 0, 1, !z, 6), rnd6(), rnd6(), z);
    end else if (op == 6'b001000) begin
      cyc(inst, pk(9, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 2), rnd6(), rnd6(), rnd1());
      cyc(inst, pk(10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2), rnd6(), rnd6(), rnd1());
    end else if (op == 6'b000010) begin
      cyc(inst, pk(11, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 2), rnd6(), rnd6(), rnd1());
    end
  endtask

  task automatic run(input int inst, input int lat);
    logic [5:0] ops[8];
    logic [5:0] fns[6];
    logic [5:0] op, fn;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b000010,
            6'b111111};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    do_instr(inst, lat, 6'b100011, rnd6(), 1'b0);
    do_instr(inst, lat, 6'b101011, rnd6(), 1'b0);
    for (int i = 0; i < 6; i++) do_instr(inst, lat, 6'b000000, fns[i], rnd1());
    do_instr(inst, lat, 6'b000100, rnd6(), 1'b1);
    do_instr(inst, lat, 6'b000100, rnd6(), 1'b0);
    do_instr(inst, lat, 6'b000101, rnd6(), 1'b0);
    do_instr(inst, lat, 6'b000101, rnd6(), 1'b1);
    do_instr(inst, lat, 6'b001000, rnd6(), 1'b0);
    do_instr(inst, lat, 6'b000010, rnd6(), 1'b0);
    for (int i = 0; i < 200; i++) begin
      op = ops[$urandom_range(7)];
      if (op == 6'b111111) op = rnd6();
      fn = ($urandom_range(3) == 0) ? rnd6() : fns[$urandom_range(5)];
      do_instr(inst, lat, op, fn, rnd1());
    end
    if (inst == 0) mon_en0 = 1'b0;
    else mon_en1 = 1'b0;
  endtask

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0;
    op0 = '0; fn0 = '0; z0 = 1'b0;
    op1 = '0; fn1 = '0; z1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst0_n = 1'b1;
    fn0 = 6'b100000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_state", int'(st0), 6);
    #1 rst0_n = 1'b0;
    #1;
    chk("rst_state", int'(st0), 0);
    chk("rst_regwrite", int'(regw0), 0);
    chk("rst_pcen", int'(pcen0), 0);
    chk("rst_irwrite", int'(irw0), 0);
    chk("rst_memwrite", int'(memw0), 0);
    chk("rst_alusrcb", int'(srcb0), 1);
    chk("rst_alucon", int'(alu0), 2);
    @(posedge clk); #1;
    chk("rst_hold_state", int'(st0), 0);
    chk("rst_hold_irwrite", int'(irw0), 0);
    chk("rst_hold_pcen", int'(pcen0), 0);
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    mon_en0 = 1'b1;
    mon_en1 = 1'b1;
    fork
      run(0, 0);
      run(1, 2);
    join
    chk("inst0_queue_left", q0.size(), 0);
    chk("inst1_queue_left", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
